eth_frame_tx: RTL and testbench

Ethernet frame serializer directly downstream of the byte-writer stage: accepts an Ethernet header (destination MAC, source MAC, EtherType) on a valid/ready header channel plus an 8-bit AXI-stream payload, and emits the complete frame as one 8-bit AXI stream. The output feeds the MAC/PHY transmit path. Header fields go out big-endian, followed by payload bytes passed through until `tlast`.

---
 rtl/eth_frame_tx_pkg.sv | 17 +
 rtl/eth_frame_tx_if.sv | 44 ++++
 rtl/eth_frame_tx.sv | 138 +++++++++++++
 tb/tb_eth_frame_tx.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_frame_tx_pkg.sv
// Shared constants and FSM state type for the Ethernet frame serializer.
package eth_frame_tx_pkg;

    localparam int ETH_HDR_BYTES   = 14;
    localparam int ETH_MIN_PAYLOAD = 46;
    localparam int ETH_MAC_W       = 48;
    localparam int ETH_TYPE_W      = 16;
    localparam int ETH_HDR_W       = 2 * ETH_MAC_W + ETH_TYPE_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PAD
    } eth_tx_state_e;

endpackage

// File: rtl/eth_frame_tx_if.sv
// Header channel, payload stream and frame output stream of the serializer.
// slave = serializer view, master = upstream/downstream environment view.
interface eth_frame_tx_if;
    import eth_frame_tx_pkg::*;

    logic                  s_eth_hdr_valid;
    logic                  s_eth_hdr_ready;
    logic [ETH_MAC_W-1:0]  s_eth_dest_mac;
    logic [ETH_MAC_W-1:0]  s_eth_src_mac;
    logic [ETH_TYPE_W-1:0] s_eth_type;

    logic [7:0]            s_eth_payload_axis_tdata;
    logic                  s_eth_payload_axis_tvalid;
    logic                  s_eth_payload_axis_tready;
    logic                  s_eth_payload_axis_tlast;
    logic                  s_eth_payload_axis_tuser;

    logic [7:0]            m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;
    logic                  m_axis_tuser;

    modport slave (
        input  s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
        output s_eth_hdr_ready,
        input  s_eth_payload_axis_tdata, s_eth_payload_axis_tvalid,
        input  s_eth_payload_axis_tlast, s_eth_payload_axis_tuser,
        output s_eth_payload_axis_tready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        input  m_axis_tready
    );

    modport master (
        output s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
        input  s_eth_hdr_ready,
        output s_eth_payload_axis_tdata, s_eth_payload_axis_tvalid,
        output s_eth_payload_axis_tlast, s_eth_payload_axis_tuser,
        input  s_eth_payload_axis_tready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        output m_axis_tready
    );

endinterface

// File: rtl/eth_frame_tx.sv
// Ethernet II frame serializer: registered 14-byte header (big-endian) followed
// by a zero-latency payload pass-through until tlast.
// Optional feature macro: ETH_FRAME_TX_MIN_PAD_EN -- zero-pads short payloads
// up to the 46-byte Ethernet minimum and moves tlast/tuser onto the last pad byte.
module eth_frame_tx
    import eth_frame_tx_pkg::*;
#(
    parameter int HDR_BYTES = ETH_HDR_BYTES
) (
    input  logic         clk,
    input  logic         rst,
    eth_frame_tx_if.slave ifc,
    output logic         busy
);

    localparam logic [3:0] HDR_LAST = 4'(HDR_BYTES - 1);
    localparam logic [5:0] MIN_PAY  = 6'(ETH_MIN_PAYLOAD);

    eth_tx_state_e        state_q;
    logic [ETH_HDR_W-1:0] hdr_q;
    logic [3:0]           hdr_cnt_q;
    logic [5:0]           pay_cnt_q;
    logic [5:0]           pay_cnt_d;
    logic                 pay_hs;

`ifdef ETH_FRAME_TX_MIN_PAD_EN
    logic                 user_q;
    logic                 pad_needed;
`endif

    // Saturating payload count as it will be after the current byte goes out.
    always_comb begin
        pay_cnt_d = (pay_cnt_q >= MIN_PAY) ? MIN_PAY : pay_cnt_q + 6'd1;
        pay_hs    = ifc.s_eth_payload_axis_tvalid & ifc.m_axis_tready;
`ifdef ETH_FRAME_TX_MIN_PAD_EN
        pad_needed = pay_cnt_d < MIN_PAY;
`endif
    end

    // Output decode: header/pad bytes come from registers, payload is passed straight through.
    always_comb begin
        // hdr_ready is gated by rst so it reads 0 while reset is held
        ifc.s_eth_hdr_ready           = (state_q == ST_IDLE) & rst;
        ifc.s_eth_payload_axis_tready = 1'b0;
        ifc.m_axis_tdata              = 8'h00;
        ifc.m_axis_tvalid             = 1'b0;
        ifc.m_axis_tlast              = 1'b0;
        ifc.m_axis_tuser              = 1'b0;
        busy                          = (state_q != ST_IDLE);
        case (state_q)
            ST_HEADER: begin
                ifc.m_axis_tvalid = 1'b1;
                ifc.m_axis_tdata  = hdr_q[ETH_HDR_W-1 -: 8];
            end
            ST_PAYLOAD: begin
                ifc.s_eth_payload_axis_tready = ifc.m_axis_tready;
                ifc.m_axis_tvalid             = ifc.s_eth_payload_axis_tvalid;
                ifc.m_axis_tdata              = ifc.s_eth_payload_axis_tdata;
`ifdef ETH_FRAME_TX_MIN_PAD_EN
                // a short frame's end marker moves to the final pad byte
                ifc.m_axis_tlast = ifc.s_eth_payload_axis_tlast & ~pad_needed;
                ifc.m_axis_tuser = ifc.s_eth_payload_axis_tuser & ~pad_needed;
`else
                ifc.m_axis_tlast = ifc.s_eth_payload_axis_tlast;
                ifc.m_axis_tuser = ifc.s_eth_payload_axis_tuser;
`endif
            end
`ifdef ETH_FRAME_TX_MIN_PAD_EN
            ST_PAD: begin
                ifc.m_axis_tvalid = 1'b1;
                ifc.m_axis_tlast  = (pay_cnt_q == MIN_PAY - 6'd1);
                ifc.m_axis_tuser  = (pay_cnt_q == MIN_PAY - 6'd1) & user_q;
            end
`endif
            default: ;
        endcase
    end

    // Frame FSM with header shift register and byte counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            hdr_q     <= '0;
            hdr_cnt_q <= '0;
            pay_cnt_q <= '0;
`ifdef ETH_FRAME_TX_MIN_PAD_EN
            user_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ifc.s_eth_hdr_valid) begin
                        hdr_q     <= {ifc.s_eth_dest_mac, ifc.s_eth_src_mac, ifc.s_eth_type};
                        hdr_cnt_q <= '0;
                        pay_cnt_q <= '0;
                        state_q   <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (ifc.m_axis_tready) begin
                        hdr_q     <= hdr_q << 8;
                        hdr_cnt_q <= hdr_cnt_q + 4'd1;
                        if (hdr_cnt_q == HDR_LAST)
                            state_q <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (pay_hs) begin
                        pay_cnt_q <= pay_cnt_d;
                        if (ifc.s_eth_payload_axis_tlast) begin
`ifdef ETH_FRAME_TX_MIN_PAD_EN
                            if (pad_needed) begin
                                user_q  <= ifc.s_eth_payload_axis_tuser;
                                state_q <= ST_PAD;
                            end else begin
                                state_q <= ST_IDLE;
                            end
`else
                            state_q <= ST_IDLE;
`endif
                        end
                    end
                end
`ifdef ETH_FRAME_TX_MIN_PAD_EN
                ST_PAD: begin
                    if (ifc.m_axis_tready) begin
                        pay_cnt_q <= pay_cnt_d;
                        if (pay_cnt_q == MIN_PAY - 6'd1)
                            state_q <= ST_IDLE;
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_frame_tx.sv
// Directed bench for eth_frame_tx: expected frame bytes are queued when a frame
// is launched and popped by a monitor on every output handshake.
module tb_eth_frame_tx;
    import eth_frame_tx_pkg::*;

    localparam int TMO = 2000;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
        logic       stable;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   mon_cnt = 0;
    int   last_tlast_cyc = 0;
    bit   rand_rdy = 1'b0;
    bit   prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    exp_t mon_e;
    exp_t sb[$];

    eth_frame_tx_if ifc();

    eth_frame_tx #(.HDR_BYTES(14)) dut (
        .clk  (clk),
        .rst  (rst),
        .ifc  (ifc),
        .busy (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        ifc.m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: compare each handshaken byte against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            mon_cnt    = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(ifc.m_axis_tvalid), 32'd1);
                chk("stall_data", 32'(ifc.m_axis_tdata), 32'(prev_data));
            end
            prev_stall = 1'b0;
            if (ifc.m_axis_tvalid) begin
                if (ifc.m_axis_tready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $error("FAIL extra_beat observed=%0h expected=none", ifc.m_axis_tdata);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("beat_data", 32'(ifc.m_axis_tdata), 32'(mon_e.data));
                        chk("beat_last", 32'(ifc.m_axis_tlast), 32'(mon_e.last));
                        chk("beat_user", 32'(ifc.m_axis_tuser), 32'(mon_e.user));
                    end
                    if (ifc.m_axis_tlast) begin
                        mon_cnt        = 0;
                        last_tlast_cyc = cyc + 1;
                    end else begin
                        mon_cnt++;
                    end
                end else if (sb.size() != 0 && sb[0].stable) begin
                    prev_stall = 1'b1;
                    prev_data  = ifc.m_axis_tdata;
                end
            end
        end
    end

    task automatic push_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                              input int n, input logic [7:0] base, input logic [7:0] step,
                              input logic user);
        logic [111:0] h;
        exp_t e;
        bit pad;
        h   = {d, s, t};
        pad = 1'b0;
`ifdef ETH_FRAME_TX_MIN_PAD_EN
        pad = (n < 46);
`endif
        for (int i = 0; i < 14; i++) begin
            e = '{data: h[111-8*i -: 8], last: 1'b0, user: 1'b0, stable: 1'b1};
            sb.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            e.data   = base + 8'(i) * step;
            e.last   = (i == n - 1) && !pad;
            e.user   = user && (i == n - 1) && !pad;
            e.stable = 1'b0;
            sb.push_back(e);
        end
        if (pad) begin
            for (int i = n; i < 46; i++) begin
                e = '{data: 8'h00, last: (i == 45), user: user && (i == 45), stable: 1'b1};
                sb.push_back(e);
            end
        end
    endtask

    // Present a header until accepted; gap = acceptance cycle minus last tlast cycle.
    task automatic drive_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                             output int gap);
        int n;
        n = 0;
        ifc.s_eth_hdr_valid = 1'b1;
        ifc.s_eth_dest_mac  = d;
        ifc.s_eth_src_mac   = s;
        ifc.s_eth_type      = t;
        do begin
            @(negedge clk);
            n++;
        end while (!(ifc.s_eth_hdr_valid && ifc.s_eth_hdr_ready) && n < TMO);
        chk("hdr_timeout", 32'(n < TMO), 32'd1);
        gap = (cyc + 1) - last_tlast_cyc;
        @(posedge clk);
        #1;
        ifc.s_eth_hdr_valid = 1'b0;
    endtask

    // Stream a payload; tvalid is raised immediately, so early bytes must be held off.
    task automatic drive_payload(input int n, input logic [7:0] base, input logic [7:0] step,
                                 input logic user);
        for (int i = 0; i < n; i++) begin
            int w;
            w = 0;
            ifc.s_eth_payload_axis_tdata  = base + 8'(i) * step;
            ifc.s_eth_payload_axis_tvalid = 1'b1;
            ifc.s_eth_payload_axis_tlast  = (i == n - 1);
            ifc.s_eth_payload_axis_tuser  = user && (i == n - 1);
            do begin
                @(negedge clk);
                w++;
                if (mon_cnt < 14)
                    chk("early_hold", 32'(ifc.s_eth_payload_axis_tready), 32'd0);
            end while (!(ifc.s_eth_payload_axis_tvalid && ifc.s_eth_payload_axis_tready) && w < TMO);
            chk("pay_timeout", 32'(w < TMO), 32'd1);
            @(posedge clk);
            #1;
        end
        ifc.s_eth_payload_axis_tvalid = 1'b0;
        ifc.s_eth_payload_axis_tlast  = 1'b0;
        ifc.s_eth_payload_axis_tuser  = 1'b0;
    endtask

    // Wait for all expected bytes to drain, then expect the block idle in that very cycle.
    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < TMO) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", 32'(n < TMO), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_hdr_ready", 32'(ifc.s_eth_hdr_ready), 32'd1);
    endtask

    initial begin
        logic [47:0] da;
        logic [47:0] sa;
        logic [15:0] ty;
        int gap;
        int n;
        da = 48'h0A0B0C0D0E0F;
        sa = 48'h112233445566;
        ty = 16'h0800;
        ifc.s_eth_hdr_valid           = 1'b0;
        ifc.s_eth_dest_mac            = '0;
        ifc.s_eth_src_mac             = '0;
        ifc.s_eth_type                = '0;
        ifc.s_eth_payload_axis_tdata  = '0;
        ifc.s_eth_payload_axis_tvalid = 1'b0;
        ifc.s_eth_payload_axis_tlast  = 1'b0;
        ifc.s_eth_payload_axis_tuser  = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hdr_ready", 32'(ifc.s_eth_hdr_ready), 32'd0);
        chk("rst_m_tvalid", 32'(ifc.m_axis_tvalid), 32'd0);
        chk("rst_m_tlast", 32'(ifc.m_axis_tlast), 32'd0);
        chk("rst_pl_tready", 32'(ifc.s_eth_payload_axis_tready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        #1;
        chk("rel_hdr_ready", 32'(ifc.s_eth_hdr_ready), 32'd1);
        @(posedge clk);
        #1;

        // 64-byte frame, continuous ready, payload presented before header
        push_frame(da, sa, ty, 64, 8'h01, 8'h01, 1'b0);
        fork
            drive_hdr(da, sa, ty, gap);
            drive_payload(64, 8'h01, 8'h01, 1'b0);
        join
        wait_drain();

        // same frame with random downstream backpressure
        rand_rdy = 1'b1;
        push_frame(da, sa, ty, 64, 8'h01, 8'h01, 1'b0);
        fork
            drive_hdr(da, sa, ty, gap);
            drive_payload(64, 8'h01, 8'h01, 1'b0);
        join
        wait_drain();
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;

        // short frame 0xAA,0xBB,0xCC with error flag on last byte
        push_frame(da, sa, ty, 3, 8'hAA, 8'h11, 1'b1);
        fork
            drive_hdr(da, sa, ty, gap);
            drive_payload(3, 8'hAA, 8'h11, 1'b1);
        join
        wait_drain();

        // back-to-back: second header held valid throughout the first frame
        push_frame(da, sa, ty, 5, 8'h50, 8'h01, 1'b0);
        push_frame(sa, da, 16'h86DD, 3, 8'h60, 8'h01, 1'b1);
        fork
            begin
                drive_hdr(da, sa, ty, gap);
                drive_hdr(sa, da, 16'h86DD, gap);
            end
            begin
                drive_payload(5, 8'h50, 8'h01, 1'b0);
                drive_payload(3, 8'h60, 8'h01, 1'b1);
            end
        join
        chk("b2b_gap", 32'(gap), 32'd1);
        wait_drain();

        // reset pulsed while header byte 5 is on the output
        push_frame(da, sa, ty, 4, 8'hC0, 8'h01, 1'b0);
        drive_hdr(da, sa, ty, gap);
        n = 0;
        while (mon_cnt < 5 && n < TMO) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rst_reach_timeout", 32'(n < TMO), 32'd1);
        chk("pre_rst_byte5", 32'(ifc.m_axis_tdata), 32'h0F);
        rst = 1'b0;
        #1;
        chk("mid_rst_tvalid", 32'(ifc.m_axis_tvalid), 32'd0);
        chk("mid_rst_tdata", 32'(ifc.m_axis_tdata), 32'd0);
        chk("mid_rst_tlast", 32'(ifc.m_axis_tlast), 32'd0);
        chk("mid_rst_hdr_ready", 32'(ifc.s_eth_hdr_ready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("post_rst_hdr_ready", 32'(ifc.s_eth_hdr_ready), 32'd1);
        @(posedge clk);
        #1;
        push_frame(da, sa, ty, 4, 8'hC0, 8'h01, 1'b1);
        fork
            drive_hdr(da, sa, ty, gap);
            drive_payload(4, 8'hC0, 8'h01, 1'b1);
        join
        wait_drain();

        repeat (5) @(posedge clk);
        #1;
        chk("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
